// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample mid-bit majority vote,
// false-start rejection, optional odd/even parity and one or two stop bits.
module uart_rx_cfg #(
  parameter int CLKS_PER_BIT = 50,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  generate
    if (CLKS_PER_BIT < 4 || DATA_BITS < 5 || DATA_BITS > 9 ||
        PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
      $error("uart_rx_cfg: illegal parameter value");
    end
  endgenerate

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam int            HALF      = CLKS_PER_BIT / 2;
  localparam logic [CW-1:0] CNT_SMP_A = CW'(HALF - 1);
  localparam logic [CW-1:0] CNT_SMP_B = CW'(HALF);
  localparam logic [CW-1:0] CNT_DEC   = CW'(HALF + 1);
  localparam logic [CW-1:0] CNT_WRAP  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic                 rx_meta, rx_s, rx_prev;
  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [3:0]           idx, idx_nxt;
  logic                 smp_a, smp_a_nxt, smp_b, smp_b_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic                 perr_acc, perr_nxt, ferr_acc, ferr_nxt;
  logic [DATA_BITS-1:0] data_out_nxt;
  logic                 data_valid_nxt, parity_err_nxt, frame_err_nxt;
  logic                 fall, vote, at_dec, at_wrap;

  // Synchroniser resets to 0 so a line held low through reset never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b0;
      rx_s    <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign fall    = !rx_s && rx_prev;
  assign vote    = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);
  assign at_dec  = (cnt == CNT_DEC);
  assign at_wrap = (cnt == CNT_WRAP);
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      idx        <= '0;
      smp_a      <= 1'b0;
      smp_b      <= 1'b0;
      shreg      <= '0;
      perr_acc   <= 1'b0;
      ferr_acc   <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      smp_a      <= smp_a_nxt;
      smp_b      <= smp_b_nxt;
      shreg      <= shreg_nxt;
      perr_acc   <= perr_nxt;
      ferr_acc   <= ferr_nxt;
      data_out   <= data_out_nxt;
      data_valid <= data_valid_nxt;
      parity_err <= parity_err_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the case can infer a latch.
    state_nxt      = state;
    cnt_nxt        = at_wrap ? '0 : cnt + CW'(1);
    idx_nxt        = idx;
    smp_a_nxt      = (cnt == CNT_SMP_A) ? rx_s : smp_a;
    smp_b_nxt      = (cnt == CNT_SMP_B) ? rx_s : smp_b;
    shreg_nxt      = shreg;
    perr_nxt       = perr_acc;
    ferr_nxt       = ferr_acc;
    data_out_nxt   = data_out;
    data_valid_nxt = 1'b0;
    parity_err_nxt = parity_err;
    frame_err_nxt  = frame_err;

    unique case (state)
      S_IDLE: begin
        cnt_nxt = '0;
        if (fall) begin
          state_nxt = S_START;
          idx_nxt   = '0;
          perr_nxt  = 1'b0;
          ferr_nxt  = 1'b0;
        end
      end
      S_START: begin
        if (at_dec && vote) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end else if (at_wrap) begin
          state_nxt = S_DATA;
          idx_nxt   = '0;
        end
      end
      S_DATA: begin
        if (at_dec) shreg_nxt = {vote, shreg[DATA_BITS-1:1]};
        if (at_wrap) begin
          if (idx == LAST_DATA) begin
            idx_nxt   = '0;
            state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_nxt = idx + 4'd1;
          end
        end
      end
      S_PARITY: begin
        if (at_dec) perr_nxt = (PARITY == 1) ? ~(^shreg ^ vote) : (^shreg ^ vote);
        if (at_wrap) begin
          state_nxt = S_STOP;
          idx_nxt   = '0;
        end
      end
      S_STOP: begin
        if (at_wrap) idx_nxt = idx + 4'd1;
        if (at_dec) begin
          ferr_nxt = ferr_acc | ~vote;
          // Leave on the last stop decision so a start bit right after it is not missed.
          if (idx == LAST_STOP) begin
            state_nxt      = S_IDLE;
            cnt_nxt        = '0;
            idx_nxt        = '0;
            data_out_nxt   = shreg;
            data_valid_nxt = 1'b1;
            parity_err_nxt = perr_acc;
            frame_err_nxt  = ferr_acc | ~vote;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver that generalises the fixed 8N1 receiver in the serial subsystem. Data width, parity mode, stop-bit count and bit period are set at elaboration time. Each bit is decided by a 3-sample majority vote at mid-bit, and false starts are rejected. Each frame is delivered as a one-cycle `data_valid` strobe, with parity and framing error flags alongside it.

## Interface
- `CLKS_PER_BIT`, 50: clock cycles per bit; legal range ≥ 4.
- `DATA_BITS`, 8: payload bits per frame; legal range 5..9.
- `PARITY`, 0: parity mode; 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: stop bits per frame; 1 or 2.

- `clk`  in  1  system clock, single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  serial line; asynchronous; idles high.
- `data_out`  out  DATA_BITS  last received payload, LSB = first bit received.
- `data_valid`  out  1  one-cycle strobe; `data_out` and the flags are updated on the same cycle.
- `parity_err`  out  1  parity mismatch on the last frame; always 0 when PARITY = 0.
- `frame_err`  out  1  a stop bit of the last frame was sampled low.
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- **Input synchroniser:** `rx` passes through 2 flops to give `rx_s`; both flops reset to 0.
- **Falling edge:** `rx_s` = 0 and its previous value = 1. Because the flops reset to 0, a line held low through reset produces no edge.
- **Bit counter and votes:**
  - HALF = CLKS_PER_BIT/2 (integer division).
  - `cnt` counts 0..CLKS_PER_BIT-1, then wraps and advances the bit index.
  - `rx_s` is sampled at `cnt` = HALF-1, HALF and HALF+1; the bit value is the 2-of-3 majority, decided at `cnt` = HALF+1.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE → START on a falling edge; `cnt` cleared to 0.
  - START: if the vote = 1 (false start), return to IDLE; no strobe, flags unchanged. If the vote = 0, enter DATA at the bit-period wrap.
  - DATA: shift votes in LSB first. After DATA_BITS bits, go to PARITY if PARITY ≠ 0, otherwise to STOP.
  - PARITY: the vote is checked against the XOR of the data bits.
    - Odd mode: error if (data XOR parity bit) = 0.
    - Even mode: error if (data XOR parity bit) = 1.
  - STOP: each stop vote must be 1; any 0 sets the frame error. At the decision point of the last stop bit, return to IDLE immediately, without waiting for the end of that bit period, so the next start edge is caught.
- **Edge handling:** edges are ignored outside IDLE.
- **Output update:** on frame completion, `data_out`, `parity_err` and `frame_err` are registered together with `data_valid` = 1. They hold until the next completed frame. False starts never modify them.
- **Bad parameters:** an illegal value must fail elaboration through a generate-time check.

## Timing
- **Reset values:** `data_out` = 0, `data_valid` = 0, `parity_err` = 0, `frame_err` = 0, `busy` = 0; state = IDLE; `cnt` = 0.
- **Definitions:**
  - T0 = the cycle the falling edge is detected. This is 2 clocks after `rx` is first sampled low.
  - NB = 1 + DATA_BITS + (PARITY ≠ 0) + STOP_BITS.
- **Cycle positions:**
  - `cnt` = 0 at T0+1.
  - The decision for bit k is made at T0+1+k·CLKS_PER_BIT+HALF+1.
  - `data_valid` is high at exactly T0 + (NB-1)·CLKS_PER_BIT + HALF + 3. Example: default 8N1, CLKS_PER_BIT = 50 gives T0+478.
- **busy:** rises at T0+1 and falls in the same cycle `data_valid` rises.
- **Frame spacing:** back-to-back frames are received with no idle gap beyond the nominal stop bit(s).
- **Reset mid-frame:** the frame is aborted and no strobe is issued. Outputs return to their reset values asynchronously. Reception resumes only after `rx_s` has been seen high and then falls.
- **Zero-length glitch:** a 1-cycle low pulse on `rx` may cause T0, but it is rejected by the START vote.

## Test plan
- **8N1 basic:** defaults; send 0xA5 then 0x3C back-to-back at exactly 50 clk/bit → two `data_valid` strobes, exactly 500 cycles apart. `data_out` = 0xA5 then 0x3C; both flags 0.
- **Even parity, 7E1:** DATA_BITS = 7, PARITY = 2; send 0x55 with a correct parity bit (0) → `parity_err` = 0. Resend with parity bit 1 → `parity_err` = 1 and `data_out` = 0x55.
- **Framing error, 8N2:** STOP_BITS = 2; send 0x81 with the second stop bit driven low → `frame_err` = 1, `data_out` = 0x81, strobe at T0+528. A following clean frame (0x00) clears `frame_err`.
- **False start:** hold `rx` low for 10 cycles, then high → `busy` pulses for about 27 cycles, no `data_valid`, outputs unchanged from the previous frame.
- **Noise rejection:** 8N1, send 0xF0 with a 1-cycle inverted spike at the HALF sample of every data bit → `data_out` = 0xF0, no errors.
- **Reset mid-frame:** assert `rst_n` low during data bit 4 of a frame, then release while `rx` is low → no strobe. `rx` then returns high and a clean 0x5A is sent → `data_out` = 0x5A.
